// File: rtl/div_controller_if.sv
// Handshake and operand/result bundle between the EX stage and the
// multi-cycle divider.
interface div_controller_if;
    logic        div_i;
    logic        signed_i;
    logic [31:0] opa_i;
    logic [31:0] opb_i;
    logic        cancel_i;
    logic        ex_ok_o;
    logic        busy_o;
    logic [31:0] lo_o;
    logic [31:0] hi_o;

    modport master (
        output div_i, signed_i, opa_i, opb_i, cancel_i,
        input  ex_ok_o, busy_o, lo_o, hi_o
    );

    modport slave (
        input  div_i, signed_i, opa_i, opb_i, cancel_i,
        output ex_ok_o, busy_o, lo_o, hi_o
    );
endinterface

// File: rtl/div_controller.sv
// Iterative 32-bit DIV/DIVU unit: one restoring radix-2 step per cycle,
// stalls EX via ex_ok_o until the quotient/remainder are ready.
module div_controller (
    input  logic            clk,
    input  logic            resetn,
    div_controller_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic [63:0] rq;
    logic [31:0] dvsr;
    logic        sgn;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] lo_q;
    logic [31:0] hi_q;

    logic        load;
    logic        load_dbz;
    logic        step;
    logic        finish;
    logic        abort;
    logic        start_ok;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] diff;
    logic [63:0] rq_step;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] q_fin;
    logic [31:0] r_fin;

    assign start_ok = bus.div_i & ~bus.cancel_i;

    assign mag_a = (bus.signed_i && bus.opa_i[31]) ? (~bus.opa_i + 32'd1) : bus.opa_i;
    assign mag_b = (bus.signed_i && bus.opb_i[31]) ? (~bus.opb_i + 32'd1) : bus.opb_i;

    // Upper 33 bits of the shifted remainder against the divisor; the
    // quotient bit enters at the bottom as the dividend shifts out.
    assign diff    = rq[63:31] - {1'b0, dvsr};
    assign rq_step = diff[32] ? {rq[62:0], 1'b0} : {diff[31:0], rq[30:0], 1'b1};

    assign neg_q = sgn & (sign_a ^ sign_b);
    assign neg_r = sgn & sign_a;
    assign q_fin = neg_q ? (~rq_step[31:0] + 32'd1)  : rq_step[31:0];
    assign r_fin = neg_r ? (~rq_step[63:32] + 32'd1) : rq_step[63:32];

    assign bus.ex_ok_o = bus.cancel_i | ~bus.div_i | (state == DONE);
    assign bus.busy_o  = (state == BUSY);
    assign bus.lo_o    = lo_q;
    assign bus.hi_o    = hi_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_dbz  = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    if (bus.opb_i == '0) begin
                        state_nxt = DONE;
                        load_dbz  = 1'b1;
                    end else begin
                        state_nxt = BUSY;
                        load      = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (bus.cancel_i) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end else begin
                    step = 1'b1;
                    if (cnt == 5'd31) begin
                        state_nxt = DONE;
                        finish    = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt    <= '0;
            rq     <= '0;
            dvsr   <= '0;
            sgn    <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            lo_q   <= '0;
            hi_q   <= '0;
        end else begin
            if (load) begin
                rq     <= {32'd0, mag_a};
                dvsr   <= mag_b;
                sgn    <= bus.signed_i;
                sign_a <= bus.opa_i[31];
                sign_b <= bus.opb_i[31];
                cnt    <= '0;
            end else if (abort) begin
                rq <= '0;
            end else if (step) begin
                rq  <= rq_step;
                cnt <= cnt + 5'd1;
            end

            // Results only move on completion, so a cancel leaves the
            // previous quotient/remainder visible.
            if (finish) begin
                lo_q <= q_fin;
                hi_q <= r_fin;
            end else if (load_dbz) begin
                lo_q <= '1;
                hi_q <= bus.opa_i;
            end
        end
    end
endmodule

// File: tb/tb_div_controller.sv
// Directed bench for div_controller: arithmetic reference model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_div_controller;
    logic clk;
    logic resetn;

    div_controller_if bus ();

    div_controller dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    function automatic logic [31:0] ref_q(bit s, logic [31:0] a, logic [31:0] b);
        longint sa;
        longint sb;
        if (!s) return a / b;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return 32'(sa / sb);
    endfunction

    function automatic logic [31:0] ref_r(bit s, logic [31:0] a, logic [31:0] b);
        longint sa;
        longint sb;
        if (!s) return a % b;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return 32'(sa % sb);
    endfunction

    // Reference: a started division occupies 32 working cycles after the
    // accepting cycle, then one completion cycle; divide-by-zero completes at once.
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_lo   = '0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_pq   = '0;
    logic [31:0] m_pr   = '0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_lo   <= '0;
            m_hi   <= '0;
        end else if (bus.cancel_i) begin
            m_left <= 0;
            m_done <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_lo   <= m_pq;
                m_hi   <= m_pr;
            end
        end else if (bus.div_i) begin
            if (bus.opb_i == 32'd0) begin
                m_done <= 1'b1;
                m_lo   <= 32'hFFFF_FFFF;
                m_hi   <= bus.opa_i;
            end else begin
                m_left <= 32;
                m_pq   <= ref_q(bus.signed_i, bus.opa_i, bus.opb_i);
                m_pr   <= ref_r(bus.signed_i, bus.opa_i, bus.opb_i);
            end
        end
    end

    always @(negedge clk) begin
        check("ex_ok", {31'd0, bus.ex_ok_o},
              {31'd0, bus.cancel_i | ~bus.div_i | m_done});
        check("busy", {31'd0, bus.busy_o}, {31'd0, m_left > 0});
        check("lo", bus.lo_o, m_lo);
        check("hi", bus.hi_o, m_hi);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a division in the current IDLE cycle and count stall cycles
    // until ex_ok_o rises; operands are scrambled mid-division.
    task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                           output int stall, output logic [31:0] lo, output logic [31:0] hi);
        bus.signed_i = s;
        bus.opa_i    = a;
        bus.opb_i    = b;
        bus.cancel_i = 1'b0;
        bus.div_i    = 1'b1;
        stall        = 0;
        #1;
        while (!bus.ex_ok_o && stall < 100) begin
            stall++;
            cyc();
            if (stall == 5) begin
                bus.opa_i = $urandom;
                bus.opb_i = $urandom;
            end
        end
        lo = bus.lo_o;
        hi = bus.hi_o;
    endtask

    task automatic end_div();
        cyc();
        bus.div_i = 1'b0;
    endtask

    typedef struct {
        bit          s;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    vec_t        vecs[$];
    int          stall;
    logic [31:0] lo;
    logic [31:0] hi;

    initial begin
        resetn       = 1'b0;
        bus.div_i    = 1'b0;
        bus.signed_i = 1'b0;
        bus.opa_i    = '0;
        bus.opb_i    = '0;
        bus.cancel_i = 1'b0;
        repeat (3) cyc();
        check("rst_lo", bus.lo_o, 32'd0);
        check("rst_hi", bus.hi_o, 32'd0);
        check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        check("rst_ex_ok", {31'd0, bus.ex_ok_o}, 32'd1);
        resetn = 1'b1;
        cyc();

        run_div(1'b0, 32'd100, 32'd7, stall, lo, hi);
        check("divu100_7_stall", stall, 33);
        check("divu100_7_lo", lo, 32'd14);
        check("divu100_7_hi", hi, 32'd2);
        end_div();
        check("divu100_7_idle", {31'd0, bus.busy_o}, 32'd0);

        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, stall, lo, hi);
        check("div_m7_2_lo", lo, 32'hFFFF_FFFD);
        check("div_m7_2_hi", hi, 32'hFFFF_FFFF);
        end_div();

        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, stall, lo, hi);
        check("div_ovf_stall", stall, 33);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'd0);
        end_div();

        run_div(1'b0, 32'd5, 32'd0, stall, lo, hi);
        check("dbz_stall", stall, 1);
        check("dbz_lo", lo, 32'hFFFF_FFFF);
        check("dbz_hi", hi, 32'd5);
        end_div();

        vecs.push_back('{1'b1, 32'd7, 32'hFFFF_FFFE});
        vecs.push_back('{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'd3});
        vecs.push_back('{1'b1, 32'd0, 32'd5});
        vecs.push_back('{1'b0, 32'd3, 32'd10});
        vecs.push_back('{1'b0, 32'h8000_0000, 32'hFFFF_FFFF});
        vecs.push_back('{1'b1, 32'hFFFF_FFF9, 32'd0});
        foreach (vecs[i]) begin
            run_div(vecs[i].s, vecs[i].a, vecs[i].b, stall, lo, hi);
            check("vec_stall", stall, (vecs[i].b == 32'd0) ? 1 : 33);
            end_div();
        end

        // Cancel on the 10th working cycle; prior result is 100/7.
        run_div(1'b0, 32'd100, 32'd7, stall, lo, hi);
        end_div();
        bus.signed_i = 1'b0;
        bus.opa_i    = 32'd1000;
        bus.opb_i    = 32'd3;
        bus.div_i    = 1'b1;
        repeat (10) cyc();
        check("pre_cancel_busy", {31'd0, bus.busy_o}, 32'd1);
        bus.cancel_i = 1'b1;
        #1;
        check("cancel_ex_ok", {31'd0, bus.ex_ok_o}, 32'd1);
        cyc();
        bus.cancel_i = 1'b0;
        bus.div_i    = 1'b0;
        #1;
        check("cancel_idle", {31'd0, bus.busy_o}, 32'd0);
        check("cancel_lo", bus.lo_o, 32'd14);
        check("cancel_hi", bus.hi_o, 32'd2);

        // Cancel together with div_i in IDLE must not start anything.
        bus.div_i    = 1'b1;
        bus.cancel_i = 1'b1;
        repeat (3) cyc();
        check("cancel_idle_nostart", {31'd0, bus.busy_o}, 32'd0);
        bus.div_i    = 1'b0;
        bus.cancel_i = 1'b0;
        cyc();

        // Reset on the 20th working cycle, then a fresh division.
        bus.opa_i = 32'd100;
        bus.opb_i = 32'd7;
        bus.div_i = 1'b1;
        repeat (20) cyc();
        resetn    = 1'b0;
        bus.opa_i = 32'd9;
        bus.opb_i = 32'd3;
        #1;
        check("mid_rst_lo", bus.lo_o, 32'd0);
        check("mid_rst_hi", bus.hi_o, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy_o}, 32'd0);
        check("mid_rst_ex_ok", {31'd0, bus.ex_ok_o}, 32'd0);
        repeat (2) cyc();
        resetn = 1'b1;
        run_div(1'b0, 32'd9, 32'd3, stall, lo, hi);
        check("post_rst_stall", stall, 33);
        check("post_rst_lo", lo, 32'd3);
        check("post_rst_hi", hi, 32'd0);
        cyc();
        run_div(1'b0, 32'd20, 32'd6, stall, lo, hi);
        check("b2b_stall", stall, 33);
        check("b2b_lo", lo, 32'd3);
        check("b2b_hi", hi, 32'd2);
        end_div();
        repeat (2) cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/div_controller.md
DIV_CONTROLLER -- requirements
Module: div_controller

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- div_i  in  1  EX stage holds a DIV/DIVU instruction; level, held while EX is stalled.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with div_i in IDLE.
- opa_i  in  32  dividend; sampled in IDLE.
- opb_i  in  32  divisor; sampled in IDLE.
- cancel_i  in  1  EX flush (exception/redirect); aborts any division in progress.
- ex_ok_o  out  1  0 = EX not finished, stall whole pipeline; feeds the stall controller.
- busy_o  out  1  state is BUSY.
- lo_o  out  32  quotient; valid only while ex_ok_o=1 in DONE.
- hi_o  out  32  remainder; valid only while ex_ok_o=1 in DONE.

Function
REQ-002 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-003 In IDLE with div_i=1, cancel_i=0 and opb_i≠0, the block SHALL latch the operand magnitudes, the sign flags and the signed_i value, clear a 5-bit iteration counter, and enter BUSY.
REQ-004 In IDLE with div_i=1, cancel_i=0 and opb_i=0, the block SHALL enter DONE directly with quotient=32'hFFFFFFFF and remainder=opa_i.
REQ-005 In BUSY, each cycle SHALL perform one restoring radix-2 step on a 64-bit partial remainder/quotient register (33-bit subtract) and increment the counter.
REQ-006 BUSY SHALL last exactly 32 cycles; when the counter equals 31, the next state SHALL be DONE.
REQ-007 DONE SHALL last exactly one cycle, with ex_ok_o=1 so the pipeline advances; the next state SHALL be IDLE unconditionally.
REQ-008 ex_ok_o SHALL be combinational: ex_ok_o = cancel_i | ~div_i | (state==DONE).
- ex_ok_o SHALL therefore be 0 in IDLE-with-div_i and throughout BUSY.
REQ-009 Latency: a nonzero-divisor division SHALL hold ex_ok_o low for 33 cycles (the IDLE cycle plus 32 BUSY cycles), and ex_ok_o SHALL rise in the 34th cycle.
- A divide-by-zero SHALL hold ex_ok_o low for 1 cycle.
REQ-010 Signed operation: the datapath SHALL divide magnitudes.
- The quotient SHALL be negated when the operand signs differ.
- The remainder SHALL take the dividend's sign.
- -2^31 / -1 SHALL yield lo=32'h80000000, hi=0.
REQ-011 Unsigned operation SHALL treat both operands as 32-bit unsigned, with no negation.
REQ-012 lo_o and hi_o SHALL be registered and SHALL hold their value from DONE until the next operand latch.
REQ-013 cancel_i=1 in any state SHALL force the next state to IDLE and discard the partial result; lo_o and hi_o SHALL retain their previous values.
REQ-014 If cancel_i and div_i are both 1 in IDLE, cancel SHALL win and no division SHALL start.
REQ-015 Back-to-back divisions: after DONE→IDLE, if div_i=1 in IDLE (a new instruction), a new division SHALL start in that IDLE cycle with no extra bubble.
REQ-016 Operand changes on opa_i or opb_i during BUSY SHALL have no effect.

Reset
REQ-017 resetn=0 SHALL asynchronously force:
- state=IDLE;
- counter=0;
- lo_o=0 and hi_o=0;
- busy_o=0;
- the internal remainder/quotient register to 0.
REQ-018 Reset mid-division SHALL abandon the operation; after resetn deasserts with div_i=1, a fresh division SHALL start from the current operands.
REQ-019 While resetn=0, ex_ok_o SHALL follow REQ-008 with state=IDLE.

Verification
REQ-020 DIVU with opa=100, opb=7, div_i held:
- ex_ok_o SHALL be 0 for 33 cycles, then 1 for one cycle;
- lo_o=14, hi_o=2;
- the block SHALL then be in IDLE.
REQ-021 DIV with opa=-7 (32'hFFFFFFF9), opb=2: lo_o=32'hFFFFFFFD (-3), hi_o=32'hFFFFFFFF (-1).
REQ-022 DIV with opa=32'h80000000, opb=32'hFFFFFFFF: lo_o=32'h80000000, hi_o=0, after 33 stall cycles.
REQ-023 DIVU with opb=0, opa=5: ex_ok_o SHALL be low for 1 cycle, then DONE with lo_o=32'hFFFFFFFF, hi_o=5.
REQ-024 Assert cancel_i on the 10th BUSY cycle:
- ex_ok_o SHALL be 1 in that cycle;
- the state SHALL be IDLE the next cycle;
- lo_o and hi_o SHALL be unchanged from the prior result.
REQ-025 Pull resetn low on the 20th BUSY cycle, then release with div_i=1, opa=9, opb=3:
- all outputs SHALL read 0 during reset;
- a full 33-cycle division SHALL follow, giving lo_o=3, hi_o=0;
- a second back-to-back division SHALL start in the cycle after DONE.
